// File: rtl/output_arbiter_pkg.sv
// Port index constants and FSM state type shared by the output arbiter and its bench.
package output_arbiter_pkg;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_W = 3'd2;
    localparam logic [2:0] PORT_S = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/output_arbiter_params.sv
// Shared NoC flit_id encodings, included by the router blocks that decode flit boundaries.
`ifndef OUTPUT_ARBITER_PARAMS_SV
`define OUTPUT_ARBITER_PARAMS_SV

`define FLIT_HEADER  3'b001
`define FLIT_PAYLOAD 3'b010
`define FLIT_TAIL    3'b100

`endif

// File: rtl/output_arbiter_rr_pick.sv
// Combinational masked priority picker: first set req bit searching cyclically from ptr+1.
module rr_pick #(
    parameter int NUM_IN = 5
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [2:0]        ptr,
    output logic [NUM_IN-1:0] onehot,
    output logic [2:0]        idx
);

    logic found;
    int   cand;

    // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        for (int i = 1; i <= NUM_IN; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_IN) cand = cand - NUM_IN;
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = 3'(cand);
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Per-output wormhole arbiter: locks the output to one input from HEADER until TAIL is popped.
// Build option: define ARB_FIXED_PRIORITY_EN for fixed priority L > N > E > W > S instead of round robin.
`include "output_arbiter_params.sv"

module output_arbiter
    import output_arbiter_pkg::*;
#(
    parameter int NUM_IN    = 5,
    parameter int FLIT_ID_W = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_IN-1:0]             req,
    input  logic [NUM_IN-1:0]             empty,
    input  logic [NUM_IN*FLIT_ID_W-1:0]   flit_id,
    input  logic                          ready,
    output logic [NUM_IN-1:0]             grant,
    output logic [2:0]                    sel,
    output logic [NUM_IN-1:0]             read_en,
    output logic                          valid_out
);

    localparam logic [FLIT_ID_W-1:0] TAIL_ID = FLIT_ID_W'(`FLIT_TAIL);

    state_t                state, state_nx;
    logic [NUM_IN-1:0]     grant_nx;
    logic [2:0]            sel_nx, ptr, ptr_nx, pick_ptr, pick_idx;
    logic [NUM_IN-1:0]     pick_onehot;
    logic [FLIT_ID_W-1:0]  head_id;
    logic                  tail_pop;

`ifdef ARB_FIXED_PRIORITY_EN
    // Searching from just after S yields the fixed order L, N, E, W, S.
    assign pick_ptr = PORT_S;
`else
    assign pick_ptr = ptr;
`endif

    rr_pick #(.NUM_IN(NUM_IN)) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    assign head_id  = flit_id[int'(sel)*FLIT_ID_W +: FLIT_ID_W];
    assign tail_pop = valid_out && (head_id == TAIL_ID);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            grant <= '0;
            sel   <= '0;
            ptr   <= 3'(NUM_IN-1);
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            sel   <= sel_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        sel_nx   = sel;
        ptr_nx   = ptr;
        unique case (state)
            ST_IDLE: begin
                if (|req) begin
                    grant_nx = pick_onehot;
                    sel_nx   = pick_idx;
                    state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Only a popped TAIL releases the lock; req is ignored while busy.
                if (tail_pop) begin
                    ptr_nx   = sel;
                    grant_nx = '0;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        read_en = '0;
        if (state == ST_BUSY) read_en = grant & ~empty & {NUM_IN{ready}};
        valid_out = |read_en;
    end

endmodule

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 SHALL take parameter NUM_IN, default 5, meaning the number of input ports, indexed 0=N, 1=E, 2=W, 3=S, 4=L.
REQ-002 SHALL take parameter FLIT_ID_W, default 3, meaning the flit_id width, with encodings HEADER/PAYLOAD/TAIL from the shared parameters include.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, NUM_IN bits: per-input request for this output, driven by that input's LBDR port bit.
REQ-006 SHALL have port empty, input, NUM_IN bits: per-input FIFO empty flag.
REQ-007 SHALL have port flit_id, input, NUM_IN*FLIT_ID_W bits: flit_id at the head of each input FIFO, input i in bits [i*FLIT_ID_W +: FLIT_ID_W].
REQ-008 SHALL have port ready, input, 1 bit: downstream can accept a flit this cycle.
REQ-009 SHALL have port grant, output, NUM_IN bits: registered one-hot (or zero) owner of the output.
REQ-010 SHALL have port sel, output, 3 bits: binary index of the granted input, used as the crossbar select.
REQ-011 SHALL have port read_en, output, NUM_IN bits: combinational pop strobe to the granted input FIFO.
REQ-012 SHALL have port valid_out, output, 1 bit: a flit is transferred downstream this cycle.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (no owner) and BUSY (packet locked to one input).
REQ-014 In IDLE with req != 0, SHALL select the first requester searching cyclically from ptr+1, register grant and sel, and enter BUSY on the next edge (1-cycle request-to-grant latency).
REQ-015 In IDLE with req == 0, SHALL stay in IDLE with grant = 0.
REQ-016 SHALL sample req only in IDLE; in BUSY, changes on req SHALL NOT affect grant.
REQ-017 In BUSY, SHALL drive read_en[g] = grant[g] & ~empty[g] & ready, all other read_en bits 0, and valid_out = |read_en.
REQ-018 In BUSY, when read_en[g] = 1 and flit_id[g] == TAIL, SHALL load ptr <= g, clear grant and return to IDLE on the next edge.
REQ-019 In BUSY with empty[g] = 1 or ready = 0, SHALL hold grant and state with no pop (stall, no timeout).
REQ-020 A HEADER flit arriving while BUSY SHALL be forwarded as ordinary data; only TAIL releases the lock.
REQ-021 After each TAIL, SHALL insert exactly one IDLE cycle before the next grant.
REQ-022 SHALL never assert read_en in IDLE and SHALL never assert more than one grant bit.

Reset
REQ-023 On rst low, SHALL asynchronously force state = IDLE, grant = 0, sel = 0 and ptr = NUM_IN-1, so the first search starts at input 0.
REQ-024 Reset mid-packet SHALL abandon the packet, and read_en/valid_out SHALL be 0 while rst is low.

Configuration
REQ-025 With ARB_FIXED_PRIORITY_EN defined, SHALL use fixed priority L > N > E > W > S, ignoring ptr.
REQ-026 Without ARB_FIXED_PRIORITY_EN, SHALL use the round-robin search of REQ-014.

Structure
REQ-027 The port index constants (N/E/W/S/L) and the FSM state enum SHALL live in the shared package, and the flit_id encodings SHALL stay in the parameters include.
REQ-028 SHALL instantiate one sub-module, rr_pick: a combinational masked priority picker taking req and ptr and producing one-hot and binary outputs.

Verification
REQ-029 Scenario: after reset, req = 5'b00110 -> grant = 5'b00010 (E) and sel = 1 one cycle later.
REQ-030 Scenario: E sends HEADER, PAYLOAD, TAIL with ready = 1 and req held at 5'b00110 -> 3 pops on input 1, one IDLE cycle, then grant = 5'b00100 (W).
REQ-031 Scenario: ready = 0 for 4 cycles mid-packet -> read_en = 0, grant unchanged, and the packet resumes on the same input when ready returns.
REQ-032 Scenario: req drops to 0 while BUSY -> grant held until the TAIL pop.
REQ-033 Scenario: rst low during PAYLOAD -> grant = 0 immediately without waiting for a clock edge, and after release req = 5'b10000 -> grant = 5'b10000.
REQ-034 Scenario: with ARB_FIXED_PRIORITY_EN, req = 5'b11111 over repeated single-flit packets -> L always granted.
